// File: rtl/rsa_run_ctrl.sv
// Run controller and data-memory arbiter between the host loader, the pipelined processor and data_mem.
// The host owns data memory outside a run and the CPU owns it during a run; run cycles are counted with an optional timeout.
module rsa_run_ctrl #(
    parameter int AW         = 32,
    parameter int RD_LAT     = 1,
    parameter int MAX_CYCLES = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_go,
    input  logic          host_abort,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic          host_ack,
    output logic [31:0]   host_rdata,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [31:0]   cycle_count,
    output logic          cpu_start,
    input  logic          cpu_end_flag,
    input  logic          cpu_mem_write,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0]  RD_LAT_W  = 2'(RD_LAT);
    localparam logic [31:0] MAX_LAST  = 32'(MAX_CYCLES - 1);
    localparam logic [31:0] COUNT_SAT = 32'hFFFF_FFFF;

    state_t        state_r;
    state_t        state_s;
    logic          ret_done_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic          we_r;
    logic [1:0]    lat_cnt_r;
    logic          host_ack_r;
    logic [31:0]   host_rdata_r;
    logic          busy_r;
    logic          done_r;
    logic          timeout_r;
    logic [31:0]   cycle_count_r;
    logic          req_take_s;
    logic          acc_fin_s;
    logic          tmo_hit_s;
    logic          run_entry_s;
    logic          done_s;
    logic          timeout_s;

    assign tmo_hit_s = (MAX_CYCLES != 0) && (cycle_count_r == MAX_LAST);

    // Next-state selection with go over req, and abort over end_flag over timeout
    always_comb begin
        state_s     = state_r;
        req_take_s  = 1'b0;
        acc_fin_s   = 1'b0;
        run_entry_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (host_go) begin
                    state_s     = ST_RUN;
                    run_entry_s = 1'b1;
                end else if (host_req) begin
                    state_s    = ST_ACCESS;
                    req_take_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ACCESS: begin
                if (we_r || (lat_cnt_r == RD_LAT_W)) begin
                    acc_fin_s = 1'b1;
                    state_s   = ret_done_r ? ST_DONE : ST_IDLE;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RUN: begin
                if (host_abort) begin
                    state_s = ST_IDLE;
                end else if (cpu_end_flag || tmo_hit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next done/timeout flags; done stays up through a host access made from DONE
    always_comb begin
        done_s    = 1'b0;
        timeout_s = timeout_r;
        if (state_s == ST_DONE) begin
            done_s = 1'b1;
        end else if (state_s == ST_ACCESS) begin
            done_s = (state_r == ST_DONE) || ((state_r == ST_ACCESS) && ret_done_r);
        end else begin
            done_s = 1'b0;
        end
        if (state_r == ST_RUN) begin
            timeout_s = (state_s == ST_DONE) && !cpu_end_flag;
        end else if (run_entry_s) begin
            timeout_s = 1'b0;
        end else begin
            timeout_s = timeout_r;
        end
    end

    // State, latched host request, read capture, run counter and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            ret_done_r    <= 1'b0;
            addr_r        <= '0;
            wdata_r       <= 32'h0;
            we_r          <= 1'b0;
            lat_cnt_r     <= 2'd0;
            host_ack_r    <= 1'b0;
            host_rdata_r  <= 32'h0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
            cycle_count_r <= 32'h0;
        end else begin
            state_r    <= state_s;
            host_ack_r <= acc_fin_s;
            busy_r     <= (state_s == ST_RUN);
            done_r     <= done_s;
            timeout_r  <= timeout_s;
            if (req_take_s) begin
                addr_r     <= host_addr;
                wdata_r    <= host_wdata;
                we_r       <= host_we;
                ret_done_r <= (state_r == ST_DONE);
                lat_cnt_r  <= 2'd0;
            end else if (state_r == ST_ACCESS) begin
                lat_cnt_r <= lat_cnt_r + 2'd1;
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
            if (acc_fin_s && !we_r) begin
                host_rdata_r <= mem_rdata;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
            if (run_entry_s) begin
                cycle_count_r <= 32'h0;
            end else if ((state_r == ST_RUN) && (cycle_count_r != COUNT_SAT)) begin
                cycle_count_r <= cycle_count_r + 32'h1;
            end else begin
                cycle_count_r <= cycle_count_r;
            end
        end
    end

    // Memory port mux: CPU passes straight through in RUN, otherwise only the latched host access
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_r;
        mem_wdata = wdata_r;
        if (state_r == ST_RUN) begin
            mem_we    = cpu_mem_write;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_we = (state_r == ST_ACCESS) && we_r && (lat_cnt_r == 2'd0);
        end
    end

    assign host_ack    = host_ack_r;
    assign host_rdata  = host_rdata_r;
    assign busy        = busy_r;
    assign cpu_start   = busy_r;
    assign done        = done_r;
    assign timeout     = timeout_r;
    assign cycle_count = cycle_count_r;

endmodule

// File: doc/rsa_run_ctrl.md
Name: rsa_run_ctrl

Overview:
- Run controller and data-memory arbiter sitting between the host/loader interface, pipelined_processor and data_mem.
- The host preloads operands into data memory, launches the CPU and waits for EndFlag. It then reads results back.
- Data-memory access is granted to the host outside a run and to the CPU during a run.
- The block also counts execution cycles and enforces an optional timeout.

Parameters:
- AW, 32, address width of data memory port
- RD_LAT, 1, data_mem read latency in cycles (address cycle to valid rdata); range 1-3
- MAX_CYCLES, 0, run timeout in cycles; 0 disables timeout

Ports:
- clk in 1 system clock, rising edge
- reset in 1 asynchronous, active-low reset
- host_go in 1 start/restart a run (sampled in IDLE/DONE)
- host_abort in 1 terminate a run in progress
- host_req in 1 host memory access request, level, held until host_ack
- host_we in 1 1=write, 0=read; valid with host_req
- host_addr in AW host address
- host_wdata in 32 host write data
- host_ack out 1 one-cycle pulse, access complete
- host_rdata out 32 read data, valid from host_ack until next access
- busy out 1 high in RUN
- done out 1 high in DONE
- timeout out 1 run ended by timeout; valid while done
- cycle_count out 32 cycles spent in current/last run
- cpu_start out 1 start level to processor
- cpu_end_flag in 1 processor EndFlag
- cpu_mem_write in 1 processor MemWrite
- cpu_addr in AW processor ALUResult (data address)
- cpu_wdata in 32 processor WriteData
- mem_we out 1 data_mem WriteEnable
- mem_addr out AW data_mem DataAddress
- mem_wdata out 32 data_mem WriteData
- mem_rdata in 32 data_mem ReadData

Behaviour:
- Reset, asynchronous on reset low:
  - State returns to IDLE.
  - All outputs are 0, and host_rdata and cycle_count are 0.
  - Reset mid-run or mid-access discards the operation silently.
- States are IDLE, ACCESS, RUN and DONE. ACCESS records a return state, either IDLE or DONE.
- Priority in IDLE/DONE:
  - host_go takes precedence over host_req. A held req is serviced after the run.
  - cpu_end_flag is ignored outside RUN.
- Host access, with host_req sampled high at edge ending cycle T in IDLE/DONE:
  - At that edge the block latches addr, wdata and we, then enters ACCESS.
  - In cycle T+1 it drives mem_addr=addr_q, mem_wdata=wdata_q and mem_we=we_q.
  - mem_we is high for exactly one cycle, T+1.
  - Write: host_ack pulses in cycle T+2, and the state returns at the same time.
  - Read: mem_addr is held through the wait. mem_rdata is captured at the end of cycle T+1+RD_LAT. host_ack and the new host_rdata appear in cycle T+2+RD_LAT.
  - The host must drop host_req in the ack cycle. A request still high after ack is a new request.
  - host_go and host_abort are ignored during ACCESS.
- RUN:
  - Entered on host_go in IDLE or DONE. On entry cycle_count, done and timeout are cleared.
  - cpu_start stays high for every RUN cycle, and busy=1.
  - mem_we, mem_addr and mem_wdata combinationally follow cpu_mem_write, cpu_addr and cpu_wdata.
  - host_req is not acknowledged during RUN.
  - cycle_count increments each RUN cycle and saturates at 2^32-1.
- RUN exits:
  - cpu_end_flag high moves to DONE at the next edge with done=1 and timeout=0. The count includes that cycle.
  - If MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1 while end_flag is low, the block moves to DONE with timeout=1.
  - If end_flag and timeout coincide, end_flag wins and timeout=0.
  - host_abort moves to IDLE with done=0 and timeout=0; cycle_count is held. abort beats end_flag in the same cycle.
- Outside RUN:
  - cpu_start=0.
  - CPU memory signals are blocked: mem_we is driven only by host ACCESS, and mem_addr/mem_wdata come from the latched host values.
- DONE: held until host_go (new run) or until a host access, which returns to DONE. cycle_count is held.

Test Plan:
- Reset low mid-RUN with cycle_count=17 -> all outputs 0, state IDLE, mem_we=0 immediately (asynchronously).
- Host write addr=0x10 data=0xA5A5_0001, then read addr=0x10 with RD_LAT=1 -> mem_we high exactly one cycle; write ack at T+2; read ack at T+3 with host_rdata=0xA5A5_0001.
- host_go, then CPU issues mem_write addr=0x20 data=0x1234 in cycle 3, then cpu_end_flag in cycle 9 -> mem signals mirror the CPU; done=1; cycle_count=9; timeout=0; cpu_start low in DONE.
- MAX_CYCLES=5 with no end_flag -> DONE after 5 RUN cycles, timeout=1, cycle_count=5. With end_flag also asserted in cycle 5 -> timeout=0.
- host_go and host_req in the same IDLE cycle -> RUN starts and req is not acked. After end_flag, req is serviced from DONE and returns to DONE.
- host_abort in RUN cycle 4 -> IDLE, cpu_start=0, done=0, cycle_count=4. CPU mem_write while in IDLE -> mem_we stays 0.
